stream_capture_fifo: RTL and testbench
======================================

Name: stream_capture_fifo

Overview:
- Downstream consumer of the enable-gated data register stage: captures every (valid, data_out) beat it produces.
- That stage has no backpressure, so this block buffers beats in a small show-ahead FIFO.
- Re-issues beats on a valid/ready interface to the next consumer.
- Counts beats dropped on overflow, for scheduler/cocotb-style test observation.

Parameters:
- DATA_WIDTH, 8, width of captured data.
- DEPTH, 8, FIFO entries; power of two, ≥2.
- AFULL_THRESH, 6, level at or above which almost_full asserts (optional feature only).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous flush of FIFO contents and statistics.
- in_valid  input  1  upstream beat present (driven from upstream valid).
- in_data  input  DATA_WIDTH  upstream beat payload (driven from upstream data_out).
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  downstream accepts head beat.
- out_data  output  DATA_WIDTH  head-of-FIFO payload.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: at least one beat dropped since reset/clear.
- drop_count  output  8  saturating count of dropped beats.
- almost_full  output  1  present only with STREAM_CAPTURE_AFULL_EN.

Behaviour:
- Reset, sync active-high, highest priority: rd_ptr = wr_ptr = 0, level = 0, out_valid = 0, overflow = 0, drop_count = 0. out_data is don't-care while out_valid = 0.
- Reset mid-operation discards all contents on that edge. Memory array is not reset.
- Pointers are ADDR_W+1 bits. Empty when pointers are equal. Full when MSBs differ and low bits are equal. level = wr_ptr − rd_ptr.
- push = in_valid && (!full || pop).
- pop = out_valid && out_ready.
- Show-ahead: out_data = mem[rd_ptr], combinational read. out_valid = !empty.
- Latency: a beat sampled at edge N is visible on out_valid/out_data after edge N, i.e. in cycle N+1.
- Push and pop together when not empty: both occur, level unchanged.
- Full with push and pop together: accepted, no drop, level stays DEPTH.
- Empty with in_valid: pop is impossible since out_valid = 0. The beat is written; there is no bypass path.
- drop = in_valid && full && !pop. On drop: data discarded, overflow set to 1, drop_count increments.
- drop_count saturates at 255 and never wraps.
- Pointer wrap-around at DEPTH is natural (modulo 2·DEPTH on the extended pointer).
- Handshake rules:
  - out_data must stay stable while out_valid && !out_ready.
  - out_valid never deasserts without a pop, except on reset or clear.
- clear, below reset, above push/pop/drop:
  - Empties the FIFO and zeroes overflow and drop_count.
  - An in_valid beat in the same cycle as clear is discarded and not counted as a drop.

Optional Feature:
- Macro: STREAM_CAPTURE_AFULL_EN.
- Defined:
  - almost_full port exists and is registered.
  - After each edge it equals (next level ≥ AFULL_THRESH).
  - Reset/clear value 0.
- Undefined:
  - Port and logic absent.
  - AFULL_THRESH is unused but still legal.

Decomposition:
- Package stream_capture_pkg holds:
  - DATA_WIDTH_DEFAULT = 8, DEPTH_DEFAULT = 8, DROP_CNT_W = 8.
  - DROP_CNT_MAX = 8'hFF.
  - typedef data_t (logic [DATA_WIDTH_DEFAULT-1:0]).
- One sub-module: stream_capture_mem, a DEPTH×DATA_WIDTH array with one synchronous write port and one asynchronous read port, no reset.
- Pointer, flag and statistics logic stays in stream_capture_fifo.

Test Plan:
- Reset: assert reset 2 cycles with in_valid = 1, in_data = 8'hAA -> out_valid = 0, level = 0, drop_count = 0, overflow = 0. After release, first beat 8'h11 -> out_valid = 1, out_data = 8'h11 the next cycle.
- Ordering: out_ready = 0, push 8'h01..8'h05 -> level = 5, out_data = 8'h01 held stable. Then out_ready = 1 -> 8'h01..8'h05 out in order, out_valid = 0 after the 5th pop.
- Full boundary: push 8 beats with out_ready = 0 -> level = 8. 9th beat 8'hEE -> drop_count = 1, overflow = 1, level = 8. Next cycle push+pop together -> no drop, level stays 8.
- Saturation/clear: hold full, drive in_valid 300 cycles -> drop_count = 255 (no wrap). Pulse clear with in_valid = 1 -> level = 0, drop_count = 0, overflow = 0, out_valid = 0.
- Wrap-around: 20 random beats, out_ready toggling 1-of-2 cycles -> output sequence equals input sequence, level never exceeds 8, no drops.
- STREAM_CAPTURE_AFULL_EN build with AFULL_THRESH = 6: push 6 beats -> almost_full = 1 after the 6th edge; pop 1 -> almost_full = 0 after that edge.

Source files
------------

// File: rtl/stream_capture_pkg.sv
// stream_capture_pkg: shared defaults and types for the stream capture FIFO
package stream_capture_pkg;
    localparam int DATA_WIDTH_DEFAULT = 8;
    localparam int DEPTH_DEFAULT = 8;
    localparam int DROP_CNT_W = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'hFF;
    typedef logic [DATA_WIDTH_DEFAULT-1:0] data_t;
endpackage

// File: rtl/stream_capture_fifo_if.sv
// stream_capture_fifo_if: upstream capture beat plus downstream valid/ready stream
interface stream_capture_fifo_if
    import stream_capture_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    modport master (output in_valid, in_data, out_ready, input out_valid, out_data);
    modport slave (input in_valid, in_data, out_ready, output out_valid, out_data);
endinterface

// File: rtl/stream_capture_mem.sv
// stream_capture_mem: DEPTH x DATA_WIDTH storage, sync write, async read, no reset
module stream_capture_mem
    import stream_capture_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    // write port; contents are never reset, the pointers define validity
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/stream_capture_fifo.sv
// stream_capture_fifo: show-ahead FIFO buffering a no-backpressure beat stream, with drop statistics
// Optional almost_full output enabled by defining STREAM_CAPTURE_AFULL_EN.
module stream_capture_fifo
    import stream_capture_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AFULL_THRESH = 6,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    stream_capture_fifo_if.slave  bus,
    output logic [ADDR_W:0]       level,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_count
`ifdef STREAM_CAPTURE_AFULL_EN
    ,
    output logic                  almost_full
`endif
);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AFULL_THRESH < 0) begin : g_bad_params
        $error("stream_capture_fifo: DEPTH must be a power of two >= 2 and AFULL_THRESH >= 0");
    end
    logic [ADDR_W:0] wr_ptr, rd_ptr;
    logic empty, full, push, pop, drop, flush;
    assign flush = reset || clear;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign pop = bus.out_valid && bus.out_ready;
    assign push = bus.in_valid && (!full || pop);
    assign drop = bus.in_valid && full && !pop;
    assign level = wr_ptr - rd_ptr;
    assign bus.out_valid = !empty;
    stream_capture_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
        .clock(clock),
        .we(push && !flush),
        .waddr(wr_ptr[ADDR_W-1:0]),
        .wdata(bus.in_data),
        .raddr(rd_ptr[ADDR_W-1:0]),
        .rdata(bus.out_data)
    );
    // extended pointers; the extra MSB separates full from empty
    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    // sticky overflow flag and saturating drop counter
    always_ff @(posedge clock) begin
        if (flush) begin
            overflow <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != DROP_CNT_MAX) drop_count <= drop_count + 1'b1;
        end
    end
`ifdef STREAM_CAPTURE_AFULL_EN
    localparam logic [ADDR_W:0] AF_TH = (ADDR_W + 1)'(AFULL_THRESH);
    logic [ADDR_W:0] level_nxt;
    assign level_nxt = level + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);
    // registered so it reflects the occupancy that exists after this edge
    always_ff @(posedge clock) begin
        almost_full <= flush ? 1'b0 : level_nxt >= AF_TH;
    end
`endif
endmodule

// File: tb/tb_stream_capture_fifo.sv
// tb_stream_capture_fifo: directed scoreboard bench for stream_capture_fifo (STREAM_CAPTURE_AFULL_EN optional)
module tb_stream_capture_fifo;
    import stream_capture_pkg::*;
    logic clock = 1'b0;
    logic reset, clear;
    logic [3:0] level;
    logic overflow;
    logic [7:0] drop_count;
`ifdef STREAM_CAPTURE_AFULL_EN
    logic almost_full;
`endif
    stream_capture_fifo_if #(.DATA_WIDTH(8)) bus ();
    stream_capture_fifo #(.DATA_WIDTH(8), .DEPTH(8), .AFULL_THRESH(6)) dut (
        .clock(clock),
        .reset(reset),
        .clear(clear),
        .bus(bus),
        .level(level),
        .overflow(overflow),
        .drop_count(drop_count)
`ifdef STREAM_CAPTURE_AFULL_EN
        ,
        .almost_full(almost_full)
`endif
    );
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    data_t q[$];
    int m_drops = 0;
    bit m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive one cycle; the queue model decides what the DUT must do at the coming edge
    task automatic cyc(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
        bit m_pop, m_full;
        bus.in_valid = v;
        bus.in_data = d;
        bus.out_ready = rdy;
        clear = clr;
        #1;
        chk("out_valid", bus.out_valid, q.size() != 0);
        m_pop = q.size() != 0 && rdy;
        m_full = q.size() == 8;
        if (clr) begin
            q.delete();
            m_drops = 0;
            m_ovf = 1'b0;
        end else begin
            if (m_pop) chk("out_data", bus.out_data, q.pop_front());
            if (v) begin
                if (!m_full || m_pop) q.push_back(d);
                else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        clear = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 8'hAA;
        bus.out_ready = 1'b0;
        repeat (n) @(posedge clock);
        @(negedge clock);
        q.delete();
        m_drops = 0;
        m_ovf = 1'b0;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_overflow", overflow, 0);
        reset = 1'b0;
    endtask

    initial begin
        int sent;
        do_reset(2);
        // first beat visible the cycle after its edge
        cyc(1, 8'h11, 0, 0);
        chk("first_valid", bus.out_valid, 1);
        chk("first_data", bus.out_data, 8'h11);
        cyc(0, 0, 1, 0);
        // ordering with held head
        for (int i = 1; i <= 5; i++) cyc(1, 8'(i), 0, 0);
        chk("ord_level", level, 5);
        chk("ord_head", bus.out_data, 8'h01);
        cyc(0, 0, 0, 0);
        chk("ord_stable", bus.out_data, 8'h01);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
        chk("ord_drained", bus.out_valid, 0);
        // full boundary
        for (int i = 0; i < 8; i++) cyc(1, 8'h20 + 8'(i), 0, 0);
        chk("full_level", level, 8);
        cyc(1, 8'hEE, 0, 0);
        chk("drop_count_1", drop_count, m_drops);
        chk("drop_count_1_abs", drop_count, 1);
        chk("overflow_set", overflow, 1);
        chk("full_level_drop", level, 8);
        cyc(1, 8'h77, 1, 0);
        chk("full_pushpop_level", level, 8);
        chk("full_pushpop_nodrop", drop_count, 1);
        // saturation then clear
        for (int i = 0; i < 300; i++) cyc(1, 8'(i), 0, 0);
        chk("drop_sat", drop_count, 8'hFF);
        chk("drop_sat_model", drop_count, m_drops);
        cyc(1, 8'h55, 0, 1);
        chk("clr_level", level, 0);
        chk("clr_drop", drop_count, 0);
        chk("clr_overflow", overflow, 0);
        chk("clr_valid", bus.out_valid, 0);
        // wrap-around with mixed push/pop
        sent = 0;
        for (int i = 0; i < 100 && sent < 20; i++) begin
            if (i % 3 != 0) begin
                cyc(1, 8'($urandom), i % 2 == 1, 0);
                sent++;
            end else cyc(0, 0, i % 2 == 1, 0);
            chk("wrap_level_bound", level <= 8, 1);
        end
        for (int i = 0; i < 20 && q.size() != 0; i++) cyc(0, 0, 1, 0);
        chk("wrap_sent", sent, 20);
        chk("wrap_empty", bus.out_valid, 0);
        chk("wrap_nodrop", drop_count, 0);
        chk("wrap_noovf", overflow, 0);
        // reset mid-operation discards contents
        for (int i = 0; i < 3; i++) cyc(1, 8'h40 + 8'(i), 0, 0);
        do_reset(1);
`ifdef STREAM_CAPTURE_AFULL_EN
        for (int i = 0; i < 5; i++) cyc(1, 8'h60 + 8'(i), 0, 0);
        chk("af_at5", almost_full, 0);
        cyc(1, 8'h65, 0, 0);
        chk("af_at6", almost_full, 1);
        cyc(0, 0, 1, 0);
        chk("af_after_pop", almost_full, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
